sound_seq_b3: RTL and testbench
===============================

Name: sound_seq_b3

Overview:
- Autonomous note sequencer for the SN76477-based sound peripheral on the AVR I/O bus.
- The CPU loads a table of up to 16 steps (VCO1 frequency + duration) and a mixer value, then starts playback.
- The block writes the sound peripheral's registers itself and arbitrates its write port against direct CPU writes, so music plays without CPU involvement.

Parameters:
- TICK_CYCLES, 100000: clk cycles per duration tick (1 ms at 100 MHz).
- STEPS, 16: step table depth; fixed at 16 (4-bit pointer).

Ports:
- clk  input  1  100MHz system clock.
- reset  input  1  asynchronous, active-low reset.
- addr  input  4  sequencer register address (CPU slave port).
- data_in  input  8  CPU write data.
- data_out  output  8  CPU read data; 0 when re=0 or address unmapped.
- re  input  1  read enable.
- we  input  1  write enable.
- cpu_snd_addr  input  4  CPU direct write address to the sound peripheral.
- cpu_snd_data  input  8  CPU direct write data.
- cpu_snd_we  input  1  CPU direct write strobe.
- snd_addr  output  4  master write address to the sound peripheral.
- snd_data  output  8  master write data.
- snd_we  output  1  master write strobe.
- busy  output  1  playback active (any state other than IDLE).
- step_idx  output  4  index of the step currently playing.

Behaviour:
- Register map, all writes on posedge clk with we=1:
  - 0x0 CTRL: bit0 START, bit1 STOP (write-1 pulses, self-clearing), bit2 LOOP (stored). Read returns {5'b0, LOOP, 1'b0, busy}.
  - 0x1 PTR: table write pointer [3:0].
  - 0x2 FLO: staging freq[7:0].
  - 0x3 FHI: staging freq[11:8] from data_in[3:0].
  - 0x4 DUR: commits {FHI, FLO, data_in} to table[PTR], then PTR <= PTR+1 (15 wraps to 0).
  - 0x5 LEN: step count [3:0]; value 0 means 16.
  - 0x6 MIX: mixer value [3:0] applied to sounding steps.
  - Reads of 0x1–0x6 return the stored value zero-extended. 0x7–0xF read 0.
- Reset values: all registers, table contents, FSM state and outputs are 0; state IDLE; busy=0; snd_we=0.
- Step semantics:
  - freq==0 is a rest: the mixer write carries 0 instead of MIX.
  - dur==0 means 256 ticks.
- FSM states: IDLE, FETCH, WR_LO, WR_HI, WR_MIX, HOLD, WR_OFF.
  - IDLE: on START go to FETCH with step_idx=0.
  - FETCH: latch table[step_idx] (1 cycle), then WR_LO.
  - WR_LO: write addr 0x0 = freq[7:0].
  - WR_HI: write addr 0x1 = {4'b0, freq[11:8]}.
  - WR_MIX: write addr 0xA = (freq!=0 ? {4'b0, MIX} : 0).
  - HOLD: counts exactly dur*TICK_CYCLES cycles, starting the cycle after the WR_MIX write is accepted; the tick prescaler restarts at entry. On expiry:
    - step_idx < LEN-1: step_idx+1, go to FETCH (no mute between steps).
    - last step and LOOP=1: step_idx=0, go to FETCH.
    - otherwise: go to WR_OFF.
  - WR_OFF: write addr 0xA = 0, then IDLE; step_idx holds its last value.
- Arbitration:
  - When cpu_snd_we=1, the master port forwards cpu_snd_addr/cpu_snd_data with snd_we=1 that cycle.
  - Any WR_* state stalls in place that cycle and retries next cycle. The CPU always wins.
  - The HOLD counter keeps running during CPU writes.
  - snd_addr/snd_data are 0 when snd_we=0.
- Control corner cases:
  - START while busy: restart immediately at FETCH, step 0.
  - STOP while busy: go to WR_OFF from any state, including mid-write and mid-HOLD.
  - START and STOP in the same write: STOP wins.
  - STOP when idle: no effect.
- Table writes during playback are allowed and take effect when that step is next fetched.
- Reset asserted mid-operation: immediate return to reset values. No mute write is issued; the sound peripheral is reset by the same reset line.

Test Plan:
- Reset/readback (TICK_CYCLES=4):
  - Stimulus: release reset, write LEN=3, MIX=0x5, PTR=2, CTRL=0x4.
  - Required: reads return 0x03, 0x05, 0x02, 0x04; busy=0; snd_we never asserted.
- Single-step playback:
  - Stimulus: load step0 freq=0x123, dur=2; LEN=1; MIX=0x1; START.
  - Required: snd writes (0x0,0x23), (0x1,0x01), (0xA,0x01); 8 cycles later (0xA,0x00); busy falls after WR_OFF.
- Rest and loop:
  - Stimulus: step0 freq=0x050 dur=1, step1 freq=0 dur=1; LEN=2; LOOP=1.
  - Required: mixer writes alternate MIX, 0, MIX, ...; step_idx sequence 0,1,0,1; no WR_OFF write until STOP.
- Arbitration:
  - Stimulus: hold cpu_snd_we=1 (addr 0x9, data 0x07) for 3 cycles coinciding with WR_HI.
  - Required: bus shows three CPU writes, then WR_HI (0x1,...) exactly once with no write lost; HOLD length unchanged.
- Stop mid-HOLD / start+stop:
  - Stimulus: STOP 5 cycles into a dur=4 HOLD.
  - Required: next master write is (0xA,0x00), then IDLE.
  - Stimulus: CTRL=0x3 while busy.
  - Required: behaves as STOP.
- Duration/LEN edges:
  - Stimulus: dur=0 and LEN=0 with all 16 steps loaded.
  - Required: first step holds 1024 cycles; 16 steps play; PTR wraps 15→0 after the 16th DUR write.

Source files
------------

// File: rtl/sound_seq_b3_if.sv
// Bus bundle for the note sequencer: CPU register port, CPU direct sound writes,
// the arbitrated master write port to the sound peripheral, and playback status.
// The sequencer takes the slave modport; the CPU side takes the master modport.
interface sound_seq_b3_if;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       re;
  logic       we;
  logic [3:0] cpu_snd_addr;
  logic [7:0] cpu_snd_data;
  logic       cpu_snd_we;
  logic [3:0] snd_addr;
  logic [7:0] snd_data;
  logic       snd_we;
  logic       busy;
  logic [3:0] step_idx;

  modport master (
    output addr, data_in, re, we, cpu_snd_addr, cpu_snd_data, cpu_snd_we,
    input  data_out, snd_addr, snd_data, snd_we, busy, step_idx
  );

  modport slave (
    input  addr, data_in, re, we, cpu_snd_addr, cpu_snd_data, cpu_snd_we,
    output data_out, snd_addr, snd_data, snd_we, busy, step_idx
  );
endinterface

// File: rtl/sound_seq_b3.sv
// Autonomous 16-step note sequencer driving the SN76477 sound peripheral registers.
// Latency: START to first peripheral write is 2 cycles (FETCH, then WR_LO).
// Backpressure: a CPU direct write always owns the port; sequencer writes stall and retry.
module sound_seq_b3 #(
  parameter int TICK_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          reset,
  sound_seq_b3_if.slave bus
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR_LO, S_WR_HI, S_WR_MIX, S_HOLD, S_WR_OFF
  } state_t;

  state_t      state;
  logic [3:0]  step_idx;
  logic [11:0] cur_freq;
  logic [7:0]  cur_dur;
  logic [TW-1:0] tick_cnt;
  logic [8:0]  ticks_left;

  logic        loop_r;
  logic [3:0]  ptr_r;
  logic [7:0]  flo_r;
  logic [3:0]  fhi_r;
  logic [3:0]  len_r;
  logic [3:0]  mix_r;
  logic [11:0] tbl_freq [16];
  logic [7:0]  tbl_dur  [16];

  logic        start_p;
  logic        stop_p;
  logic        busy;
  logic        wr_req;
  logic        wr_ok;
  logic [3:0]  last_idx;
  logic [3:0]  fsm_addr;
  logic [7:0]  fsm_data;

  assign start_p  = bus.we && (bus.addr == 4'h0) && bus.data_in[0];
  assign stop_p   = bus.we && (bus.addr == 4'h0) && bus.data_in[1];
  assign busy     = (state != S_IDLE);
  // LEN of 0 means 16 steps; the 4-bit wrap of 0-1 gives index 15.
  assign last_idx = len_r - 4'd1;
  assign wr_req   = (state == S_WR_LO) || (state == S_WR_HI) ||
                    (state == S_WR_MIX) || (state == S_WR_OFF);
  // The CPU always wins the port; a sequencer write only lands when it is idle.
  assign wr_ok    = !bus.cpu_snd_we;

  assign bus.busy     = busy;
  assign bus.step_idx = step_idx;

  // Register file and step table writes from the CPU slave port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_r <= 1'b0;
      ptr_r  <= 4'h0;
      flo_r  <= 8'h00;
      fhi_r  <= 4'h0;
      len_r  <= 4'h0;
      mix_r  <= 4'h0;
      for (int i = 0; i < 16; i++) begin
        tbl_freq[i] <= 12'h000;
        tbl_dur[i]  <= 8'h00;
      end
    end else if (bus.we) begin
      case (bus.addr)
        4'h0: loop_r <= bus.data_in[2];
        4'h1: ptr_r  <= bus.data_in[3:0];
        4'h2: flo_r  <= bus.data_in;
        4'h3: fhi_r  <= bus.data_in[3:0];
        4'h4: begin
          tbl_freq[ptr_r] <= {fhi_r, flo_r};
          tbl_dur[ptr_r]  <= bus.data_in;
          ptr_r           <= ptr_r + 4'd1;
        end
        4'h5: len_r  <= bus.data_in[3:0];
        4'h6: mix_r  <= bus.data_in[3:0];
        default: ;
      endcase
    end
  end

  // CPU read mux; unmapped addresses and re=0 read as zero.
  always_comb begin
    bus.data_out = 8'h00;
    if (bus.re) begin
      case (bus.addr)
        4'h0: bus.data_out = {5'b0, loop_r, 1'b0, busy};
        4'h1: bus.data_out = {4'b0, ptr_r};
        4'h2: bus.data_out = flo_r;
        4'h3: bus.data_out = {4'b0, fhi_r};
        4'h5: bus.data_out = {4'b0, len_r};
        4'h6: bus.data_out = {4'b0, mix_r};
        default: bus.data_out = 8'h00;
      endcase
    end
  end

  // Peripheral register write the current state wants to make.
  always_comb begin
    fsm_addr = 4'h0;
    fsm_data = 8'h00;
    case (state)
      S_WR_LO:  begin fsm_addr = 4'h0; fsm_data = cur_freq[7:0]; end
      S_WR_HI:  begin fsm_addr = 4'h1; fsm_data = {4'b0, cur_freq[11:8]}; end
      S_WR_MIX: begin fsm_addr = 4'hA; fsm_data = (cur_freq != 12'h000) ? {4'b0, mix_r} : 8'h00; end
      S_WR_OFF: begin fsm_addr = 4'hA; fsm_data = 8'h00; end
      default:  ;
    endcase
  end

  // Master port mux: CPU direct write first, then the sequencer, else a quiet zero bus.
  always_comb begin
    bus.snd_we   = 1'b0;
    bus.snd_addr = 4'h0;
    bus.snd_data = 8'h00;
    if (bus.cpu_snd_we) begin
      bus.snd_we   = 1'b1;
      bus.snd_addr = bus.cpu_snd_addr;
      bus.snd_data = bus.cpu_snd_data;
    end else if (wr_req) begin
      bus.snd_we   = 1'b1;
      bus.snd_addr = fsm_addr;
      bus.snd_data = fsm_data;
    end
  end

  // Playback FSM: STOP beats START, START restarts from step 0, HOLD counts dur ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      step_idx   <= 4'h0;
      cur_freq   <= 12'h000;
      cur_dur    <= 8'h00;
      tick_cnt   <= '0;
      ticks_left <= 9'd0;
    end else if (stop_p && busy) begin
      state <= S_WR_OFF;
    end else if (start_p && !stop_p) begin
      state    <= S_FETCH;
      step_idx <= 4'h0;
    end else begin
      case (state)
        S_IDLE: ;
        S_FETCH: begin
          cur_freq <= tbl_freq[step_idx];
          cur_dur  <= tbl_dur[step_idx];
          state    <= S_WR_LO;
        end
        S_WR_LO:  if (wr_ok) state <= S_WR_HI;
        S_WR_HI:  if (wr_ok) state <= S_WR_MIX;
        S_WR_MIX: if (wr_ok) begin
          state      <= S_HOLD;
          tick_cnt   <= '0;
          ticks_left <= (cur_dur == 8'h00) ? 9'd256 : {1'b0, cur_dur};
        end
        S_HOLD: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (ticks_left == 9'd1) begin
              if (step_idx < last_idx) begin
                step_idx <= step_idx + 4'd1;
                state    <= S_FETCH;
              end else if (loop_r) begin
                step_idx <= 4'h0;
                state    <= S_FETCH;
              end else begin
                state <= S_WR_OFF;
              end
            end else begin
              ticks_left <= ticks_left - 9'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        S_WR_OFF: if (wr_ok) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_seq_b3.sv
module tb_sound_seq_b3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   quiet_err = 0;

  logic [3:0] lg_addr [$];
  logic [7:0] lg_data [$];
  logic [3:0] lg_idx  [$];
  int         lg_cyc  [$];

  sound_seq_b3_if bus ();

  sound_seq_b3 #(.TICK_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every peripheral write; a deasserted strobe must leave the bus at zero.
  always @(negedge clk) begin
    if (bus.snd_we === 1'b1) begin
      lg_addr.push_back(bus.snd_addr);
      lg_data.push_back(bus.snd_data);
      lg_idx.push_back(bus.step_idx);
      lg_cyc.push_back(cyc);
    end else if (bus.snd_addr !== 4'h0 || bus.snd_data !== 8'h00) begin
      quiet_err++;
    end
  end

  task automatic clear_log();
    lg_addr.delete(); lg_data.delete(); lg_idx.delete(); lg_cyc.delete();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.addr = 4'h0; bus.data_in = 8'h00;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.re = 1'b1; bus.addr = a;
    @(negedge clk);
    d = bus.data_out;
    bus.re = 1'b0; bus.addr = 4'h0;
  endtask

  task automatic load_step(input logic [3:0] p, input logic [11:0] f, input logic [7:0] d);
    wr(4'h1, {4'h0, p});
    wr(4'h2, f[7:0]);
    wr(4'h3, {4'h0, f[11:8]});
    wr(4'h4, d);
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", nm, bus.busy, maxc);
    end
  endtask

  task automatic wait_log(input int n, input int maxc, input string nm);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (lg_addr.size() < n && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++;
    if (lg_addr.size() < n) begin
      n_fail++;
      $display("FAIL %s: %0d writes logged, required %0d", nm, lg_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #2;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.step_idx !== 4'h0 || bus.snd_we !== 1'b0 || bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b idx=%h we=%b dout=%h, required 0/0/0/00",
               bus.busy, bus.step_idx, bus.snd_we, bus.data_out);
    end
    @(posedge clk); #1 reset = 1'b1;
    rd(4'h5, v);
    n_cmp++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_len: read %h, required 00", v); end
    wr(4'h5, 8'h03);
    wr(4'h6, 8'h05);
    wr(4'h1, 8'h02);
    wr(4'h0, 8'h04);
    rd(4'h5, v);
    n_cmp++;
    if (v !== 8'h03) begin n_fail++; $display("FAIL rd_len: read %h, required 03", v); end
    rd(4'h6, v);
    n_cmp++;
    if (v !== 8'h05) begin n_fail++; $display("FAIL rd_mix: read %h, required 05", v); end
    rd(4'h1, v);
    n_cmp++;
    if (v !== 8'h02) begin n_fail++; $display("FAIL rd_ptr: read %h, required 02", v); end
    rd(4'h0, v);
    n_cmp++;
    if (v !== 8'h04) begin n_fail++; $display("FAIL rd_ctrl: read %h, required 04", v); end
    rd(4'h7, v);
    n_cmp++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL rd_unmapped: read %h, required 00", v); end
    n_cmp++;
    if (bus.busy !== 1'b0 || lg_addr.size() != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: busy=%b writes=%0d, required 0/0", bus.busy, lg_addr.size());
    end
    wr(4'h0, 8'h00);
  endtask

  task automatic test_single();
    logic [3:0] ea [4];
    logic [7:0] ed [4];
    ea = '{4'h0, 4'h1, 4'hA, 4'hA};
    ed = '{8'h23, 8'h01, 8'h01, 8'h00};
    load_step(4'h0, 12'h123, 8'd2);
    wr(4'h5, 8'h01);
    wr(4'h6, 8'h01);
    clear_log();
    wr(4'h0, 8'h01);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: busy=%b, required 1", bus.busy); end
    wait_idle(100, "single_idle");
    n_cmp++;
    if (lg_addr.size() != 4) begin
      n_fail++;
      $display("FAIL single_count: %0d writes, required 4", lg_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (lg_addr[i] !== ea[i] || lg_data[i] !== ed[i]) begin
          n_fail++;
          $display("FAIL single_wr%0d: got (%h,%h), required (%h,%h)", i, lg_addr[i], lg_data[i], ea[i], ed[i]);
        end
      end
      // HOLD occupies 8 cycles after the mixer write, then the mute lands.
      n_cmp++;
      if (lg_cyc[1] - lg_cyc[0] != 1 || lg_cyc[2] - lg_cyc[1] != 1 || lg_cyc[3] - lg_cyc[2] != 9) begin
        n_fail++;
        $display("FAIL single_timing: gaps %0d/%0d/%0d, required 1/1/9",
                 lg_cyc[1] - lg_cyc[0], lg_cyc[2] - lg_cyc[1], lg_cyc[3] - lg_cyc[2]);
      end
    end
  endtask

  task automatic test_rest_loop();
    logic [3:0] ea [6];
    logic [7:0] ed [6];
    logic [3:0] ei [4];
    ea = '{4'h0, 4'h1, 4'hA, 4'h0, 4'h1, 4'hA};
    ed = '{8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    ei = '{4'h0, 4'h1, 4'h0, 4'h1};
    load_step(4'h0, 12'h050, 8'd1);
    load_step(4'h1, 12'h000, 8'd1);
    wr(4'h5, 8'h02);
    wr(4'h6, 8'h05);
    clear_log();
    wr(4'h0, 8'h05);
    wait_log(12, 200, "loop_progress");
    if (lg_addr.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (lg_addr[i] !== ea[i % 6] || lg_data[i] !== ed[i % 6]) begin
          n_fail++;
          $display("FAIL loop_wr%0d: got (%h,%h), required (%h,%h)", i, lg_addr[i], lg_data[i], ea[i % 6], ed[i % 6]);
        end
      end
      for (int s = 0; s < 4; s++) begin
        n_cmp++;
        if (lg_idx[3 * s + 2] !== ei[s]) begin
          n_fail++;
          $display("FAIL loop_idx%0d: step_idx %h, required %h", s, lg_idx[3 * s + 2], ei[s]);
        end
      end
      // 4-cycle hold, one FETCH cycle, then WR_LO of the next step.
      n_cmp++;
      if (lg_cyc[3] - lg_cyc[2] != 6) begin
        n_fail++;
        $display("FAIL loop_gap: %0d cycles, required 6", lg_cyc[3] - lg_cyc[2]);
      end
    end
    wr(4'h0, 8'h06);
    wait_idle(20, "loop_stop_idle");
    n_cmp++;
    if (lg_addr[lg_addr.size() - 1] !== 4'hA || lg_data[lg_data.size() - 1] !== 8'h00) begin
      n_fail++;
      $display("FAIL loop_mute: last write (%h,%h), required (a,00)",
               lg_addr[lg_addr.size() - 1], lg_data[lg_data.size() - 1]);
    end
    wr(4'h0, 8'h00);
  endtask

  task automatic test_arbitration();
    logic [3:0] ea [7];
    logic [7:0] ed [7];
    int         ec [7];
    ea = '{4'h0, 4'h9, 4'h9, 4'h9, 4'h1, 4'hA, 4'hA};
    ed = '{8'h23, 8'h07, 8'h07, 8'h07, 8'h01, 8'h01, 8'h00};
    ec = '{0, 1, 2, 3, 4, 5, 14};
    load_step(4'h0, 12'h123, 8'd2);
    wr(4'h5, 8'h01);
    wr(4'h6, 8'h01);
    clear_log();
    wr(4'h0, 8'h01);
    @(posedge clk);
    @(posedge clk); #1;
    bus.cpu_snd_we = 1'b1; bus.cpu_snd_addr = 4'h9; bus.cpu_snd_data = 8'h07;
    repeat (3) @(posedge clk);
    #1;
    bus.cpu_snd_we = 1'b0; bus.cpu_snd_addr = 4'h0; bus.cpu_snd_data = 8'h00;
    wait_idle(100, "arb_idle");
    n_cmp++;
    if (lg_addr.size() != 7) begin
      n_fail++;
      $display("FAIL arb_count: %0d writes, required 7", lg_addr.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (lg_addr[i] !== ea[i] || lg_data[i] !== ed[i] || lg_cyc[i] - lg_cyc[0] != ec[i]) begin
          n_fail++;
          $display("FAIL arb_wr%0d: got (%h,%h)@+%0d, required (%h,%h)@+%0d",
                   i, lg_addr[i], lg_data[i], lg_cyc[i] - lg_cyc[0], ea[i], ed[i], ec[i]);
        end
      end
    end
  endtask

  task automatic test_stop();
    load_step(4'h0, 12'h123, 8'd4);
    wr(4'h5, 8'h01);
    // STOP when idle does nothing.
    clear_log();
    wr(4'h0, 8'h02);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || lg_addr.size() != 0) begin
      n_fail++;
      $display("FAIL stop_idle: busy=%b writes=%0d, required 0/0", bus.busy, lg_addr.size());
    end
    // STOP five cycles into a 16-cycle HOLD.
    wr(4'h0, 8'h01);
    wait_log(3, 50, "stop_hold_mix");
    repeat (4) @(posedge clk);
    wr(4'h0, 8'h02);
    wait_idle(20, "stop_hold_idle");
    n_cmp++;
    if (lg_addr.size() != 4 || lg_addr[3] !== 4'hA || lg_data[3] !== 8'h00 || lg_cyc[3] - lg_cyc[2] != 6) begin
      n_fail++;
      $display("FAIL stop_hold: %0d writes, last (%h,%h) gap %0d, required 4 writes, (a,00), gap 6",
               lg_addr.size(), lg_addr[lg_addr.size() - 1], lg_data[lg_data.size() - 1],
               lg_cyc[lg_cyc.size() - 1] - lg_cyc[2]);
    end
    // START and STOP together mid-write act as STOP.
    clear_log();
    wr(4'h0, 8'h01);
    wait_log(1, 20, "startstop_lo");
    wr(4'h0, 8'h03);
    wait_idle(20, "startstop_idle");
    n_cmp++;
    if (lg_addr.size() != 3 || lg_addr[2] !== 4'hA || lg_data[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL start_stop: %0d writes, last (%h,%h), required 3 writes ending (a,00)",
               lg_addr.size(), lg_addr[lg_addr.size() - 1], lg_data[lg_data.size() - 1]);
    end
  endtask

  task automatic test_edges();
    logic [7:0] v;
    wr(4'h1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      wr(4'h2, 8'h10 + 8'(i));
      wr(4'h3, 8'h02);
      wr(4'h4, (i == 0) ? 8'h00 : 8'h01);
    end
    rd(4'h1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ptr_wrap: read %h, required 00", v); end
    wr(4'h5, 8'h00);
    wr(4'h6, 8'h03);
    clear_log();
    wr(4'h0, 8'h01);
    wait_idle(3000, "edges_idle");
    n_cmp++;
    if (lg_addr.size() != 49) begin
      n_fail++;
      $display("FAIL edges_count: %0d writes, required 49", lg_addr.size());
    end else begin
      // dur=0 holds 256 ticks of 4 cycles, plus FETCH before the next WR_LO.
      n_cmp++;
      if (lg_cyc[3] - lg_cyc[2] != 1026) begin
        n_fail++;
        $display("FAIL edges_dur0: gap %0d, required 1026", lg_cyc[3] - lg_cyc[2]);
      end
      n_cmp++;
      if (lg_data[45] !== 8'h1F || lg_data[47] !== 8'h03 || lg_idx[47] !== 4'hF) begin
        n_fail++;
        $display("FAIL edges_last: lo=%h mix=%h idx=%h, required 1f/03/f", lg_data[45], lg_data[47], lg_idx[47]);
      end
      n_cmp++;
      if (lg_addr[48] !== 4'hA || lg_data[48] !== 8'h00 || bus.step_idx !== 4'hF) begin
        n_fail++;
        $display("FAIL edges_off: (%h,%h) idx=%h, required (a,00) idx=f", lg_addr[48], lg_data[48], bus.step_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    wr(4'h0, 8'h01);
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.step_idx !== 4'h0 || bus.snd_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b idx=%h we=%b, required 0/0/0", bus.busy, bus.step_idx, bus.snd_we);
    end
    @(posedge clk); #1 reset = 1'b1;
    rd(4'h6, v);
    n_cmp++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_mid_mix: read %h, required 00", v); end
  endtask

  initial begin
    bus.addr = 4'h0; bus.data_in = 8'h00; bus.re = 1'b0; bus.we = 1'b0;
    bus.cpu_snd_addr = 4'h0; bus.cpu_snd_data = 8'h00; bus.cpu_snd_we = 1'b0;
    test_reset();
    test_single();
    test_rest_loop();
    test_arbitration();
    test_stop();
    test_edges();
    test_reset_mid();
    n_cmp++;
    if (quiet_err != 0) begin
      n_fail++;
      $display("FAIL quiet_bus: %0d cycles with nonzero bus while snd_we=0, required 0", quiet_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
